// File: rtl/mips_wb_pkg.sv
// Shared definitions for the MIPS writeback stage: load type codes, FSM
// state encoding, timeout fill word and a byte/half extension helper.
package mips_wb_pkg;

    typedef enum logic [2:0] {
        LT_LB  = 3'd0,
        LT_LBU = 3'd1,
        LT_LH  = 3'd2,
        LT_LHU = 3'd3,
        LT_LW  = 3'd4
    } load_type_e;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1,
        WB_WRITE    = 2'd2
    } wb_state_e;

    localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

    // Extends a sub-word value of width 'bits' (8 or 16) to 32 bits.
    function automatic logic [31:0] extend_sub(input logic [15:0] val, input logic is_half,
                                               input logic is_signed);
        logic [31:0] r;
        if (is_half) begin
            r = {(is_signed && val[15]) ? 16'hFFFF : 16'h0000, val};
        end else begin
            r = {(is_signed && val[7]) ? 24'hFFFFFF : 24'h000000, val[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_load_formatter.sv
// Combinational load formatter: little-endian lane select, sign/zero
// extension and misalignment detection for LB/LBU/LH/LHU/LW.
module mips_load_formatter
    import mips_wb_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_load_type,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Byte lane selection by address low bits.
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Extension and alignment per load type; codes 5..7 behave as LW.
    always_comb begin
        o_data     = i_rdata;
        o_misalign = (i_addr_lo != 2'd0);
        case (i_load_type)
            LT_LB: begin
                o_data     = extend_sub({8'h00, w_byte}, 1'b0, 1'b1);
                o_misalign = 1'b0;
            end
            LT_LBU: begin
                o_data     = extend_sub({8'h00, w_byte}, 1'b0, 1'b0);
                o_misalign = 1'b0;
            end
            LT_LH: begin
                o_data     = extend_sub(w_half, 1'b1, 1'b1);
                o_misalign = i_addr_lo[0];
            end
            LT_LHU: begin
                o_data     = extend_sub(w_half, 1'b1, 1'b0);
                o_misalign = i_addr_lo[0];
            end
            default: begin
                o_data     = i_rdata;
                o_misalign = (i_addr_lo != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mips_writeback_stage.sv
// MIPS writeback stage: registers results, waits for load data by handshake,
// drives the register file write port. Optional macro: WB_LOAD_TIMEOUT_EN.
module mips_writeback_stage
    import mips_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    input  logic        in_is_load,
    input  logic [2:0]  in_load_type,
    input  logic [1:0]  in_addr_lo,
    input  logic [31:0] in_alu_result,
    input  logic        mem_rdata_valid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  reg_write_idx,
    output logic        reg_write_enable,
    output logic [31:0] reg_write_data,
    output logic        stall,
    output logic        align_err,
    output logic        timeout_err
);

    wb_state_e   r_state, w_state_nxt;
    logic [4:0]  r_ld_rd;
    logic        r_ld_regwrite;
    logic [2:0]  r_ld_type;
    logic [1:0]  r_ld_addr_lo;
    logic [4:0]  r_idx;
    logic        r_we;
    logic [31:0] r_data;
    logic        r_align_err;

    logic        w_accept, w_timeout, w_misalign;
    logic [31:0] w_fmt_data;
    logic [4:0]  w_idx_nxt;
    logic        w_we_nxt, w_align_nxt;
    logic [31:0] w_data_nxt;

    assign in_ready         = (r_state != WB_WAIT_MEM);
    assign stall            = ~in_ready;
    assign w_accept         = in_valid & in_ready;
    assign reg_write_idx    = r_idx;
    assign reg_write_enable = r_we;
    assign reg_write_data   = r_data;
    assign align_err        = r_align_err;

    mips_load_formatter u_fmt (
        .i_rdata     (mem_rdata),
        .i_load_type (r_ld_type),
        .i_addr_lo   (r_ld_addr_lo),
        .o_data      (w_fmt_data),
        .o_misalign  (w_misalign)
    );

    // Next state and next write-port values.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_we_nxt    = 1'b0;
        w_data_nxt  = r_data;
        w_align_nxt = 1'b0;
        case (r_state)
            WB_IDLE, WB_WRITE: begin
                if (w_accept && in_is_load) begin
                    w_state_nxt = WB_WAIT_MEM;
                end else if (w_accept) begin
                    w_state_nxt = WB_WRITE;
                    w_idx_nxt   = in_rd;
                    w_we_nxt    = in_regwrite && (in_rd != 5'd0);
                    w_data_nxt  = in_alu_result;
                end else begin
                    w_state_nxt = WB_IDLE;
                end
            end
            WB_WAIT_MEM: begin
                if (mem_rdata_valid) begin
                    w_state_nxt = WB_WRITE;
                    w_idx_nxt   = r_ld_rd;
                    w_we_nxt    = r_ld_regwrite && (r_ld_rd != 5'd0) && !w_misalign;
                    w_data_nxt  = w_fmt_data;
                    w_align_nxt = w_misalign;
                end else if (w_timeout) begin
                    w_state_nxt = WB_WRITE;
                    w_idx_nxt   = r_ld_rd;
                    w_we_nxt    = r_ld_regwrite && (r_ld_rd != 5'd0);
                    w_data_nxt  = TIMEOUT_FILL;
                end else begin
                    w_state_nxt = WB_WAIT_MEM;
                end
            end
            default: w_state_nxt = WB_IDLE;
        endcase
    end

    // State and write-port registers; data only moves on an enabled write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= WB_IDLE;
            r_idx       <= 5'd0;
            r_we        <= 1'b0;
            r_data      <= 32'd0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_we        <= w_we_nxt;
            r_data      <= w_we_nxt ? w_data_nxt : r_data;
            r_align_err <= w_align_nxt;
        end
    end

    // Pending-load context captured at accept time.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ld_rd       <= 5'd0;
            r_ld_regwrite <= 1'b0;
            r_ld_type     <= 3'd0;
            r_ld_addr_lo  <= 2'd0;
        end else if (w_accept && in_is_load) begin
            r_ld_rd       <= in_rd;
            r_ld_regwrite <= in_regwrite;
            r_ld_type     <= in_load_type;
            r_ld_addr_lo  <= in_addr_lo;
        end else begin
            r_ld_rd       <= r_ld_rd;
            r_ld_regwrite <= r_ld_regwrite;
            r_ld_type     <= r_ld_type;
            r_ld_addr_lo  <= r_ld_addr_lo;
        end
    end

`ifdef WB_LOAD_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_tmo_cnt;
    logic                 r_timeout_err;

    // Returned data in the final wait cycle wins over the timeout.
    assign w_timeout   = (r_state == WB_WAIT_MEM) && !mem_rdata_valid &&
                         (r_tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept && in_is_load) begin
                r_tmo_cnt <= '0;
            end else if (r_state == WB_WAIT_MEM) begin
                r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
            end else begin
                r_tmo_cnt <= r_tmo_cnt;
            end
            r_timeout_err <= r_timeout_err | w_timeout;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_writeback_stage.sv
// Self-checking bench for mips_writeback_stage: directed vector table,
// hand-written multi-cycle sequences and randomized transactions vs a model.
module tb_mips_writeback_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_rd = 5'd0;
    logic        in_regwrite = 1'b0, in_is_load = 1'b0;
    logic [2:0]  in_load_type = 3'd0;
    logic [1:0]  in_addr_lo = 2'd0;
    logic [31:0] in_alu_result = 32'd0;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [4:0]  reg_write_idx;
    logic        reg_write_enable;
    logic [31:0] reg_write_data;
    logic        stall, align_err, timeout_err;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_last = 32'd0;

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic        rw;
        logic [2:0]  lt;
        logic [1:0]  alo;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          delay;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_aerr;
    } vec_t;

    mips_writeback_stage #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .in_is_load(in_is_load),
        .in_load_type(in_load_type), .in_addr_lo(in_addr_lo),
        .in_alu_result(in_alu_result), .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata(mem_rdata), .reg_write_idx(reg_write_idx),
        .reg_write_enable(reg_write_enable), .reg_write_data(reg_write_data),
        .stall(stall), .align_err(align_err), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [4:0] rd, input logic rw,
                                input logic [2:0] lt, input logic [1:0] alo,
                                input logic [31:0] alu, input logic [31:0] rdata,
                                input int dly, input logic we, input logic [31:0] d,
                                input logic ae);
        vec_t v;
        v.is_load = ld; v.rd = rd; v.rw = rw; v.lt = lt; v.alo = alo; v.alu = alu;
        v.rdata = rdata; v.delay = dly; v.exp_we = we; v.exp_data = d; v.exp_aerr = ae;
        return v;
    endfunction

    // Reference: what the register file should see for one transaction.
    function automatic vec_t model(input vec_t v);
        vec_t        r = v;
        int          sh = 8 * int'(v.alo);
        int          hsh = 16 * (int'(v.alo) / 2);
        logic [7:0]  b = 8'(v.rdata >> sh);
        logic [15:0] h = 16'(v.rdata >> hsh);
        logic        mis = 1'b0;
        if (!v.is_load) begin
            r.exp_data = v.alu;
        end else if (v.lt == 3'd0) begin
            r.exp_data = 32'($signed(b));
        end else if (v.lt == 3'd1) begin
            r.exp_data = 32'(b);
        end else if (v.lt == 3'd2) begin
            r.exp_data = 32'($signed(h));
            mis = (int'(v.alo) % 2) != 0;
        end else if (v.lt == 3'd3) begin
            r.exp_data = 32'(h);
            mis = (int'(v.alo) % 2) != 0;
        end else begin
            r.exp_data = v.rdata;
            mis = (v.alo != 2'd0);
        end
        r.exp_we   = v.rw && (v.rd != 5'd0) && !mis;
        r.exp_aerr = v.is_load && mis;
        return r;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        @(negedge clock);
        in_valid = 1'b1; in_rd = v.rd; in_regwrite = v.rw; in_is_load = v.is_load;
        in_load_type = v.lt; in_addr_lo = v.alo; in_alu_result = v.alu;
        @(negedge clock);
        in_valid = 1'b0; in_is_load = 1'b0;
        if (v.is_load) begin
            for (int k = 0; k < v.delay; k++) begin
                chk({tag, " stall"}, 32'(stall), 32'd1);
                if (k == v.delay - 1) begin
                    mem_rdata = v.rdata;
                    mem_rdata_valid = 1'b1;
                end
                @(negedge clock);
            end
            mem_rdata_valid = 1'b0;
        end
        chk({tag, " we"}, 32'(reg_write_enable), 32'(v.exp_we));
        chk({tag, " align_err"}, 32'(align_err), 32'(v.exp_aerr));
        chk({tag, " ready"}, 32'(in_ready), 32'd1);
        if (v.exp_we) begin
            chk({tag, " idx"}, 32'(reg_write_idx), 32'(v.rd));
            chk({tag, " data"}, reg_write_data, v.exp_data);
            m_last = v.exp_data;
        end else begin
            chk({tag, " data hold"}, reg_write_data, m_last);
        end
        @(negedge clock);
        chk({tag, " we pulse end"}, 32'(reg_write_enable), 32'd0);
        chk({tag, " align pulse end"}, 32'(align_err), 32'd0);
    endtask

    initial begin
        vec_t tbl[13];
        vec_t rv;

        tbl[0]  = mk(1'b0, 5'd5,  1'b1, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 1, 1'b1, 32'h1234_5678, 1'b0);
        tbl[1]  = mk(1'b1, 5'd3,  1'b1, 3'd0, 2'd2, 32'h0, 32'h0080_0000, 3, 1'b1, 32'hFFFF_FF80, 1'b0);
        tbl[2]  = mk(1'b1, 5'd3,  1'b1, 3'd1, 2'd2, 32'h0, 32'h0080_0000, 3, 1'b1, 32'h0000_0080, 1'b0);
        tbl[3]  = mk(1'b1, 5'd4,  1'b1, 3'd2, 2'd1, 32'h0, 32'h1234_5678, 2, 1'b0, 32'h0, 1'b1);
        tbl[4]  = mk(1'b1, 5'd6,  1'b1, 3'd3, 2'd2, 32'h0, 32'hBEEF_0000, 1, 1'b1, 32'h0000_BEEF, 1'b0);
        tbl[5]  = mk(1'b1, 5'd9,  1'b1, 3'd4, 2'd0, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 32'hCAFE_F00D, 1'b0);
        tbl[6]  = mk(1'b1, 5'd9,  1'b1, 3'd4, 2'd3, 32'h0, 32'h1111_2222, 1, 1'b0, 32'h0, 1'b1);
        tbl[7]  = mk(1'b1, 5'd10, 1'b1, 3'd6, 2'd0, 32'h0, 32'h0102_0304, 1, 1'b1, 32'h0102_0304, 1'b0);
        tbl[8]  = mk(1'b1, 5'd11, 1'b1, 3'd0, 2'd3, 32'h0, 32'h7F00_0000, 2, 1'b1, 32'h0000_007F, 1'b0);
        tbl[9]  = mk(1'b1, 5'd12, 1'b1, 3'd2, 2'd0, 32'h0, 32'h0000_8001, 1, 1'b1, 32'hFFFF_8001, 1'b0);
        tbl[10] = mk(1'b0, 5'd13, 1'b0, 3'd0, 2'd0, 32'hAAAA_5555, 32'h0, 1, 1'b0, 32'h0, 1'b0);
        tbl[11] = mk(1'b1, 5'd0,  1'b1, 3'd4, 2'd0, 32'h0, 32'h5555_AAAA, 1, 1'b0, 32'h0, 1'b0);
        tbl[12] = mk(1'b1, 5'd14, 1'b1, 3'd3, 2'd3, 32'h0, 32'h9999_8888, 3, 1'b0, 32'h0, 1'b1);

        // Reset state while reset is held low.
        repeat (2) @(negedge clock);
        chk("rst ready", 32'(in_ready), 32'd1);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst we", 32'(reg_write_enable), 32'd0);
        chk("rst idx", 32'(reg_write_idx), 32'd0);
        chk("rst data", reg_write_data, 32'd0);
        chk("rst align", 32'(align_err), 32'd0);
        chk("rst timeout", 32'(timeout_err), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Data-valid while idle must be ignored.
        @(negedge clock);
        mem_rdata = 32'h7777_7777; mem_rdata_valid = 1'b1;
        @(negedge clock);
        mem_rdata_valid = 1'b0;
        chk("idle valid we", 32'(reg_write_enable), 32'd0);
        chk("idle valid stall", 32'(stall), 32'd0);
        chk("idle valid data", reg_write_data, m_last);

        // Back-to-back non-loads to rd 1, 2, 0.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                chk($sformatf("b2b%0d ready", i), 32'(in_ready), 32'd1);
                chk($sformatf("b2b%0d we", i), 32'(reg_write_enable), (i == 3) ? 32'd0 : 32'd1);
                if (i < 3) begin
                    chk($sformatf("b2b%0d idx", i), 32'(reg_write_idx), 32'(i));
                    chk($sformatf("b2b%0d data", i), reg_write_data, 32'h100 + 32'(i));
                    m_last = 32'h100 + 32'(i);
                end
            end
            if (i < 3) begin
                in_valid = 1'b1; in_is_load = 1'b0; in_regwrite = 1'b1;
                in_rd = (i == 2) ? 5'd0 : 5'(i + 1);
                in_alu_result = 32'h100 + 32'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
        end
        chk("b2b end we", 32'(reg_write_enable), 32'd0);

        // Reset pulse during WAIT_MEM drops the pending load.
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd7; in_regwrite = 1'b1;
        in_load_type = 3'd4; in_addr_lo = 2'd0;
        @(negedge clock);
        in_valid = 1'b0; in_is_load = 1'b0;
        chk("rstwait stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rstwait ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        mem_rdata = 32'h1357_9BDF; mem_rdata_valid = 1'b1;
        @(negedge clock);
        mem_rdata_valid = 1'b0;
        chk("rstwait we", 32'(reg_write_enable), 32'd0);
        chk("rstwait data", reg_write_data, 32'd0);
        chk("rstwait ready2", 32'(in_ready), 32'd1);
        m_last = 32'd0;

`ifdef WB_LOAD_TIMEOUT_EN
        // No data: four WAIT cycles then the fill word, flag sticky until reset.
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd8; in_regwrite = 1'b1;
        in_load_type = 3'd0; in_addr_lo = 2'd1;
        @(negedge clock);
        in_valid = 1'b0; in_is_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tmo stall%0d", k), 32'(stall), 32'd1);
            @(negedge clock);
        end
        chk("tmo we", 32'(reg_write_enable), 32'd1);
        chk("tmo idx", 32'(reg_write_idx), 32'd8);
        chk("tmo data", reg_write_data, 32'hDEAD_BEEF);
        chk("tmo flag", 32'(timeout_err), 32'd1);
        repeat (3) @(negedge clock);
        chk("tmo flag held", 32'(timeout_err), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("tmo flag cleared", 32'(timeout_err), 32'd0);
        m_last = 32'd0;
`endif

        // Randomized transactions against the reference model.
        for (int i = 0; i < 60; i++) begin
            rv = mk($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), $urandom, $urandom,
                    $urandom_range(1, 4), 1'b0, 32'd0, 1'b0);
            run_op(model(rv), $sformatf("rnd%0d", i));
        end
        chk("end timeout flag", 32'(timeout_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
